cobertura_ctrl: RTL
===================

# cobertura_ctrl

Sequencing controller for the motorised retractable roof (cobertura). It filters the light (L) and rain (U) sensors and drives the motor open (A) and close (F) commands with a Moore FSM. Motion stops on the end-of-travel switches Fd (fully open) and Fe (fully closed). The block enforces a dead-time before any direction reversal, a motion timeout, and a latched fault state. It sits between the raw sensor/limit-switch inputs and the motor driver.

## Interface
- DEB_CYC, 4: consecutive identical samples required before a filtered L/U value changes (≥2)
- TIMEOUT, 1000: maximum clocks allowed in ABRINDO/FECHANDO before a fault
- DEAD, 8: motor-off clocks held in PAUSA before a reversal
- clk  in  1  system clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- L  in  1  raw light sensor (1 = strong light, roof must close)
- U  in  1  raw rain sensor (1 = rain, roof must close)
- Fd  in  1  open limit switch (1 = fully open)
- Fe  in  1  closed limit switch (1 = fully closed)
- clr_falha  in  1  single-cycle fault clear
- A  out  1  motor open command
- F  out  1  motor close command
- estado  out  3  current state code
- falha  out  1  fault flag

## Operation
- Filtering applies to L and U only. Per input there is a filtered bit and a counter.
  - While raw == filtered, the counter clears.
  - While raw != filtered, the counter increments. On the DEB_CYC-th consecutive mismatching sample, filtered takes the raw value and the counter clears.
  - Filtered bits reset to 0.
- Fd and Fe are used unfiltered, sampled at each clock edge.
- want_close = Lf | Uf. want_open = ~Lf & ~Uf.
- States and codes: PARADA=0, ABRINDO=1, FECHANDO=2, PAUSA=3, FALHA=4.
- PARADA: if want_close & ~Fe, go to FECHANDO. Else if want_open & ~Fd, go to ABRINDO. Else stay.
- ABRINDO: if Fd, go to PARADA. Else if want_close, go to PAUSA. Else if the timer reaches TIMEOUT-1, go to FALHA.
- FECHANDO: if Fe, go to PARADA. Else if want_open, go to PAUSA. Else if the timer reaches TIMEOUT-1, go to FALHA.
- PAUSA: motor off. After DEAD clocks in PAUSA, go to PARADA, which then re-evaluates the inputs.
- FALHA: motor off, falha=1. Only clr_falha=1 or a reset leaves FALHA, going to PARADA.
- Fd & Fe both 1 while in any non-FALHA state: go to FALHA (sensor fault). This has the highest priority.
- Priority within a motion state: sensor fault > limit switch > reversal > timeout.
- Outputs are decoded from the state register only:
  - A = (estado==ABRINDO)
  - F = (estado==FECHANDO)
  - falha = (estado==FALHA)
  - A and F are never both 1.
- Timer: clears on every state change and increments each clock in ABRINDO, FECHANDO and PAUSA. Its width is clog2(max(TIMEOUT, DEAD)) bits, and it never wraps.

## Timing
- Reset (rst_n=0 at an edge): state = PARADA, A=0, F=0, falha=0, estado=0, filtered bits 0, counters 0.
- Reset takes effect mid-motion on the same edge, with no dead-time.
- Sensor latency: raw L/U changes before edge k and holds.
  - Filtered value changes at edge k+DEB_CYC-1.
  - State and A/F change at edge k+DEB_CYC.
- A glitch shorter than DEB_CYC clocks has no effect.
- Limit-switch latency: Fd/Fe high at edge k gives A/F low after edge k.
- Reversal: the motor is off for exactly DEAD clocks in PAUSA plus 1 clock in PARADA before the opposite command asserts.
- Timeout: FALHA is entered on the TIMEOUT-th edge spent in a motion state. If a limit switch and the timeout coincide on the same edge, the limit switch wins and the next state is PARADA.
- clr_falha while not in FALHA is ignored.

## Structure
- Shared package/include `cobertura_pkg`: state codes (PARADA..FALHA) and the 3-bit estado width.
- Sub-module `filtro_sensor` (parameter DEB_CYC; ports clk, rst_n, din, dout) is instantiated twice, once for L and once for U.
- The top module holds the FSM, the shared timer and the output decode.

## Test plan
All scenarios use DEB_CYC=4, TIMEOUT=20, DEAD=3.
- Reset with L=U=0, Fd=Fe=0 → A=F=0 during reset. The first edge after release gives A=1 (estado=1). Fd=1 → A=0, estado=0.
- Estado=ABRINDO, U pulsed high for 3 clocks → no change. U held high → estado=3 at edge 4, then 3 clocks of A=F=0, then PARADA, then F=1.
- FECHANDO with Fe never asserting → estado=4 and falha=1 on the 20th edge. A clr_falha pulse → estado=0 on the next edge.
- Fd=Fe=1 during ABRINDO → FALHA on the next edge with A=0. L/U changes while in FALHA leave outputs unchanged.
- Fe asserted on the same edge the timer hits 19 in FECHANDO → estado=0, falha=0.
- rst_n=0 for one edge during FECHANDO → F=0 and estado=0 on that edge, with no PAUSA.

Source files
------------

// File: rtl/cobertura_pkg.sv
// Shared definitions for the retractable-roof controller: state codes,
// the estado width and a small elaboration-time helper.
package cobertura_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    PARADA   = 3'd0,
    ABRINDO  = 3'd1,
    FECHANDO = 3'd2,
    PAUSA    = 3'd3,
    FALHA    = 3'd4
  } estado_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Debounce filter for one raw sensor bit: the output follows the input only
// after DEB_CYC consecutive samples that disagree with the current output.
module filtro_sensor #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/cobertura_ctrl.sv
// Roof sequencing controller: debounced light/rain sensors drive a Moore FSM
// that commands the motor with reversal dead-time, motion timeout and fault latch.
module cobertura_ctrl
  import cobertura_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int TIMEOUT = 1000,
  parameter int DEAD    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                L,
  input  logic                U,
  input  logic                Fd,
  input  logic                Fe,
  input  logic                clr_falha,
  output logic                A,
  output logic                F,
  output logic [ESTADO_W-1:0] estado,
  output logic                falha
);

  localparam int TMAX    = max_int(TIMEOUT, DEAD);
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_DEAD    = TIMER_W'(DEAD - 1);

  logic l_f, u_f;
  logic want_close, want_open;

  estado_e            state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  filtro_sensor #(.DEB_CYC(DEB_CYC)) u_filtro_l (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (L),
    .dout (l_f)
  );

  filtro_sensor #(.DEB_CYC(DEB_CYC)) u_filtro_u (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (U),
    .dout (u_f)
  );

  assign want_close = l_f | u_f;
  assign want_open  = ~l_f & ~u_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PARADA;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Both limit switches closed is physically impossible: treat it as a
  // sensor fault ahead of every other condition.
  always_comb begin
    state_d = state_q;
    if ((state_q != FALHA) && Fd && Fe) begin
      state_d = FALHA;
    end else begin
      unique case (state_q)
        PARADA: begin
          if (want_close && !Fe)     state_d = FECHANDO;
          else if (want_open && !Fd) state_d = ABRINDO;
        end
        ABRINDO: begin
          if (Fd)                          state_d = PARADA;
          else if (want_close)             state_d = PAUSA;
          else if (timer_q == T_TIMEOUT)   state_d = FALHA;
        end
        FECHANDO: begin
          if (Fe)                          state_d = PARADA;
          else if (want_open)              state_d = PAUSA;
          else if (timer_q == T_TIMEOUT)   state_d = FALHA;
        end
        PAUSA: begin
          if (timer_q == T_DEAD) state_d = PARADA;
        end
        FALHA: begin
          if (clr_falha) state_d = PARADA;
        end
        default: state_d = PARADA;
      endcase
    end
  end

  // Shared timer: restarts on every transition and saturates instead of wrapping.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == ABRINDO || state_q == FECHANDO || state_q == PAUSA)
                 && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    A      = (state_q == ABRINDO);
    F      = (state_q == FECHANDO);
    falha  = (state_q == FALHA);
    estado = state_q;
  end

endmodule
